dm_banked_latency: RTL and testbench

- Parametrised successor to the single-cycle word data memory for the MIPS pipeline.
- Adds byte and halfword stores and loads (sb/sh/sw, lb/lbu/lh/lhu) with sign or zero extension.
- Adds configurable access latency with a Req/Ready handshake and a Stall output toward the hazard unit.
- Flags misaligned accesses as AdEL/AdES instead of silently truncating the address.

---
 rtl/dm_banked_latency.sv | 209 ++++++++++++++++++++
 tb/tb_dm_banked_latency.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dm_banked_latency.sv
// dm_banked_latency
//   Data memory for the MIPS pipeline with byte/halfword/word access,
//   configurable access latency and a Req/Ready handshake. Misaligned
//   accesses are reported as AdEL (load) or AdES (store) instead of
//   touching memory.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 32-bit words held
//   LATENCY    : edges from request acceptance to the memory operation (1..15)
//   TRACE      : nonzero prints one line per committed write in simulation
//
// Ports
//   clk      in   system clock, all state updates on posedge
//   Reset    in   synchronous active-high reset, clears memory and handshake
//   PC       in   PC of the requesting instruction, kept for the write trace
//   Req      in   access request, held with its fields until Ready
//   WE       in   1 = store, 0 = load
//   Size     in   00 byte, 01 half, 10/11 word
//   SignExt  in   load extension, 1 = sign, 0 = zero
//   Address  in   byte address
//   Data     in   right-aligned store data
//   Ready    out  one-cycle completion pulse
//   DataRead out  load result, valid with Ready on loads, 0 after stores/errors
//   Stall    out  Req & ~Ready, toward the hazard unit
//   AdEL     out  misaligned load, valid with Ready
//   AdES     out  misaligned store, valid with Ready
module dm_banked_latency #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1,
  parameter int TRACE      = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Req,
  input  logic        WE,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Address,
  input  logic [31:0] Data,
  output logic        Ready,
  output logic [31:0] DataRead,
  output logic        Stall,
  output logic        AdEL,
  output logic        AdES
);

  localparam int WORDS = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t state, state_next;

  logic        accept;
  logic        misaligned;
  logic        fire;
  logic [3:0]  cnt;

  logic [31:0] lpc;
  logic [31:0] laddr;
  logic [31:0] ldata;
  logic        lwe;
  logic        lsext;
  logic [1:0]  lsize;

  logic [31:0] mem [WORDS];
  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0] oldword;
  logic [31:0] merged;
  logic [31:0] loadval;
  logic [7:0]  bytesel;
  logic [15:0] halfsel;

  // A new request may be taken whenever no access is in flight, including
  // the completion cycle itself so a held Req streams back-to-back.
  assign accept     = Req && (state != BUSY);
  assign misaligned = ((Size == 2'b01) && Address[0]) ||
                      (Size[1] && (Address[1:0] != 2'b00));
  // Memory operation happens on the edge where the countdown has expired.
  assign fire       = (state == BUSY) && (cnt == 4'd0);

  // Upper address bits are dropped so accesses wrap around the array.
  assign widx    = laddr[DEPTH_LOG2+1:2];
  assign oldword = mem[widx];

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. LATENCY=1 also passes through BUSY, with the counter
  // already at zero, so the operation lands on the following edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (Req) begin
          state_next = misaligned ? ERR : BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; completion and exception flags follow the state directly.
  always_comb begin
    Ready = (state == DONE) || (state == ERR);
    AdEL  = (state == ERR) && !lwe;
    AdES  = (state == ERR) && lwe;
    Stall = Req && !Ready;
  end

  // Request latch, latency countdown and load result register. The fields
  // are latched on every acceptance because ERR still needs WE to pick
  // between AdEL and AdES.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt      <= 4'd0;
      lpc      <= 32'd0;
      laddr    <= 32'd0;
      ldata    <= 32'd0;
      lwe      <= 1'b0;
      lsext    <= 1'b0;
      lsize    <= 2'b00;
      DataRead <= 32'd0;
    end else begin
      if (accept) begin
        lpc   <= PC;
        laddr <= Address;
        ldata <= Data;
        lwe   <= WE;
        lsext <= SignExt;
        lsize <= Size;
        if (misaligned) begin
          cnt      <= 4'd0;
          DataRead <= 32'd0;
        end else begin
          cnt <= 4'(LATENCY - 1);
        end
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (fire) begin
        DataRead <= lwe ? 32'd0 : loadval;
      end
    end
  end

  // Store merge: only the addressed byte or half is replaced, the rest of
  // the word is carried over from the current contents.
  always_comb begin
    merged = oldword;
    case (lsize)
      2'b00:   merged[{laddr[1:0], 3'b000} +: 8] = ldata[7:0];
      2'b01: begin
        if (laddr[1]) begin
          merged[31:16] = ldata[15:0];
        end else begin
          merged[15:0] = ldata[15:0];
        end
      end
      default: merged = ldata;
    endcase
  end

  // Load lane select and extension.
  always_comb begin
    bytesel = oldword[{laddr[1:0], 3'b000} +: 8];
    halfsel = laddr[1] ? oldword[31:16] : oldword[15:0];
    case (lsize)
      2'b00:   loadval = {{24{lsext & bytesel[7]}}, bytesel};
      2'b01:   loadval = {{16{lsext & halfsel[15]}}, halfsel};
      default: loadval = oldword;
    endcase
  end

  // Storage array. Reset wipes every word in one edge, and because Reset
  // also forces the FSM out of BUSY an in-flight store never commits.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (fire && lwe) begin
      mem[widx] <= merged;
    end
  end

`ifndef SYNTHESIS
  // Write trace for simulation runs.
  always_ff @(posedge clk) begin
    if ((TRACE != 0) && !Reset && fire && lwe) begin
      $display("@%h: *%h <= %h", lpc, {laddr[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

// File: tb/tb_dm_banked_latency.sv
// tb_dm_banked_latency
//   Directed bench for dm_banked_latency. Two instances share the access
//   fields: one with LATENCY=1 and one with LATENCY=4, each with its own
//   Req and Reset. Expected values are hand-computed constants.
module tb_dm_banked_latency;

  logic        clk;
  logic        rst1, rst4;
  logic        req1, req4;
  logic [31:0] pc;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] data;

  logic        rdy1, stall1, adel1, ades1;
  logic [31:0] dr1;
  logic        rdy4, stall4, adel4, ades4;
  logic [31:0] dr4;

  logic        sel4;
  logic        rdy, stall, adel, ades;
  logic [31:0] dr;

  int checkCount;
  int passCount;

  dm_banked_latency #(.DEPTH_LOG2(10), .LATENCY(1), .TRACE(1)) u1 (
    .clk(clk), .Reset(rst1), .PC(pc), .Req(req1), .WE(we), .Size(size),
    .SignExt(sext), .Address(addr), .Data(data), .Ready(rdy1),
    .DataRead(dr1), .Stall(stall1), .AdEL(adel1), .AdES(ades1)
  );

  dm_banked_latency #(.DEPTH_LOG2(10), .LATENCY(4), .TRACE(1)) u4 (
    .clk(clk), .Reset(rst4), .PC(pc), .Req(req4), .WE(we), .Size(size),
    .SignExt(sext), .Address(addr), .Data(data), .Ready(rdy4),
    .DataRead(dr4), .Stall(stall4), .AdEL(adel4), .AdES(ades4)
  );

  // Observe whichever instance the current access targets.
  assign rdy   = sel4 ? rdy4   : rdy1;
  assign stall = sel4 ? stall4 : stall1;
  assign adel  = sel4 ? adel4  : adel1;
  assign ades  = sel4 ? ades4  : ades1;
  assign dr    = sel4 ? dr4    : dr1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One access: drive fields at a negedge, hold Req until Ready, check the
  // latency, the stall, the result and the exception flags. With hold=1 Req
  // stays high so the next call is accepted straight out of DONE.
  task automatic applyStimulus(input string tag, input logic use4,
                               input logic w, input logic [1:0] sz,
                               input logic sx, input logic [31:0] a,
                               input logic [31:0] d, input logic hold,
                               input logic [31:0] expData, input logic expErr);
    int cycles;
    int expLat;
    logic got;
    expLat = expErr ? 1 : ((use4 ? 4 : 1) + 1);
    @(negedge clk);
    sel4 = use4;
    pc   = pc + 32'd4;
    we   = w;
    size = sz;
    sext = sx;
    addr = a;
    data = d;
    if (use4) req4 = 1'b1; else req1 = 1'b1;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1 && !expErr) checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd1);
      if (rdy) got = 1'b1;
    end
    checkOutput({tag, "_lat"}, cycles, expLat);
    checkOutput({tag, "_data"}, dr, expData);
    checkOutput({tag, "_adel"}, {31'd0, adel}, {31'd0, expErr & ~w});
    checkOutput({tag, "_ades"}, {31'd0, ades}, {31'd0, expErr & w});
    checkOutput({tag, "_nostall"}, {31'd0, stall}, 32'd0);
    if (!hold) begin
      @(negedge clk);
      req1 = 1'b0;
      req4 = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, "_pulse"}, {31'd0, rdy}, 32'd0);
    end
  endtask

  initial begin
    int pulses;
    checkCount = 0;
    passCount  = 0;
    rst1 = 1'b1; rst4 = 1'b1;
    req1 = 1'b0; req4 = 1'b0;
    pc = 32'h0040_0000; we = 1'b0; size = 2'b10; sext = 1'b0;
    addr = 32'd0; data = 32'd0; sel4 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'd0, rdy1}, 32'd0);
    checkOutput("rst_data", dr1, 32'd0);
    checkOutput("rst_adel", {31'd0, adel1}, 32'd0);
    checkOutput("rst_ades", {31'd0, ades1}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall1}, 32'd0);
    @(negedge clk);
    rst1 = 1'b0; rst4 = 1'b0;

    // LATENCY=1 word store/load, then byte/half merges and extensions.
    applyStimulus("sw10", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw10", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5678, 1'b0);
    applyStimulus("sb11", 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB, 1'b0, 32'h0, 1'b0);
    applyStimulus("sh12", 1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1111_BEEF, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw10m", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hBEEF_AB78, 1'b0);
    applyStimulus("lb11", 1'b0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFAB, 1'b0);
    applyStimulus("lbu11", 1'b0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000_00AB, 1'b0);
    applyStimulus("lh12", 1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF_BEEF, 1'b0);
    applyStimulus("lhu12", 1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0000_BEEF, 1'b0);
    applyStimulus("lb10", 1'b0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000_0078, 1'b0);

    // Misaligned accesses.
    applyStimulus("lw13", 1'b0, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 1'b1);
    applyStimulus("sh21", 1'b0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_1111, 1'b0, 32'h0, 1'b1);
    applyStimulus("lw20", 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw10k", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hBEEF_AB78, 1'b0);

    // Address wrap: 0x1000 aliases word 0 with 1024 words.
    applyStimulus("sw1000", 1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw0", 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);

    // LATENCY=4 back-to-back with Req held high throughout.
    applyStimulus("b2b_sw30", 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5_0001, 1'b1, 32'h0, 1'b0);
    applyStimulus("b2b_lw30", 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0);
    applyStimulus("b2b_sb37", 1'b1, 1'b1, 2'b00, 1'b0, 32'h37, 32'h0000_00C3, 1'b1, 32'h0, 1'b0);
    applyStimulus("b2b_lw34", 1'b1, 1'b0, 2'b10, 1'b0, 32'h34, 32'h0, 1'b0, 32'hC300_0000, 1'b0);

    // LATENCY=4 store aborted by Reset two edges after acceptance.
    @(negedge clk);
    sel4 = 1'b1;
    we = 1'b1; size = 2'b10; sext = 1'b0; addr = 32'h40; data = 32'h0000_0055;
    req4 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst4 = 1'b1;
    pulses = 0;
    @(posedge clk);
    #1;
    if (rdy4) pulses++;
    @(negedge clk);
    rst4 = 1'b0;
    req4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rdy4) pulses++;
    end
    checkOutput("abort_pulses", pulses, 32'd0);
    checkOutput("abort_data", dr4, 32'd0);
    applyStimulus("abort_lw40", 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
